// File: rtl/axi_sram_slave.sv
// AXI3 slave backed by a word-organised RAM: independent read and write engines,
// one outstanding transaction each, INCR/WRAP bursts, SLVERR on out-of-range or illegal bursts.
module axi_sram_slave #(
  parameter int unsigned DEPTH  = 1024,
  parameter int unsigned RD_LAT = 2,
  parameter int unsigned B_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  // read address
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic        arvalid,
  output logic        arready,
  // read data
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  // write address
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic        awvalid,
  output logic        awready,
  // write data
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  // write response
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam int unsigned BL_W  = (B_LAT > 1) ? $clog2(B_LAT) : 1;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  logic [31:0] mem [DEPTH];

  // WRAP only for 2/4/8/16-beat bursts; anything else steps linearly
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [7:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    logic [31:0] b;
    logic [31:0] l;
    b = 32'd1 << size;
    l = (32'(len) + 32'd1) << size;
    if (burst == 2'b10 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15))
      next_addr = (a & ~(l - 32'd1)) | ((a + b) & (l - 32'd1));
    else
      next_addr = a + b;
  endfunction

  function automatic logic in_range(input logic [31:0] a);
    in_range = ({2'b00, a[31:2]} < DEPTH);
  endfunction

  // ---------------- read engine ----------------
  r_state_t          r_state, r_state_nxt;
  logic [31:0]       r_addr, r_addr_nxt;
  logic [7:0]        r_len, r_len_nxt;
  logic [2:0]        r_size, r_size_nxt;
  logic [1:0]        r_burst, r_burst_nxt;
  logic [7:0]        r_cnt, r_cnt_nxt;
  logic [LAT_W-1:0]  r_lat, r_lat_nxt;
  logic              r_err, r_err_nxt;
  logic              arready_nxt, rvalid_nxt, rlast_nxt;
  logic [1:0]        rresp_nxt;
  logic [3:0]        rid_nxt;
  logic              rd_load;
  logic [31:0]       rd_addr;
  logic [31:0]       r_step;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= R_IDLE;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      r_lat   <= '0;
      r_err   <= 1'b0;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rresp   <= OKAY;
      rid     <= '0;
      rdata   <= '0;
    end else begin
      r_state <= r_state_nxt;
      r_addr  <= r_addr_nxt;
      r_len   <= r_len_nxt;
      r_size  <= r_size_nxt;
      r_burst <= r_burst_nxt;
      r_cnt   <= r_cnt_nxt;
      r_lat   <= r_lat_nxt;
      r_err   <= r_err_nxt;
      arready <= arready_nxt;
      rvalid  <= rvalid_nxt;
      rlast   <= rlast_nxt;
      rresp   <= rresp_nxt;
      rid     <= rid_nxt;
      // read-before-write: a same-cycle write to this word is not seen
      if (rd_load)
        rdata <= in_range(rd_addr) ? mem[rd_addr[AW+1:2]] : '0;
    end
  end

  always_comb begin
    r_state_nxt = r_state;
    r_addr_nxt  = r_addr;
    r_len_nxt   = r_len;
    r_size_nxt  = r_size;
    r_burst_nxt = r_burst;
    r_cnt_nxt   = r_cnt;
    r_lat_nxt   = r_lat;
    r_err_nxt   = r_err;
    arready_nxt = arready;
    rvalid_nxt  = rvalid;
    rlast_nxt   = rlast;
    rresp_nxt   = rresp;
    rid_nxt     = rid;
    rd_load     = 1'b0;
    rd_addr     = r_addr;
    r_step      = next_addr(r_addr, r_len, r_size, r_burst);
    case (r_state)
      R_IDLE: begin
        if (arvalid && arready) begin
          r_state_nxt = R_WAIT;
          arready_nxt = 1'b0;
          rid_nxt     = arid;
          r_addr_nxt  = araddr;
          r_len_nxt   = arlen;
          r_size_nxt  = arsize;
          r_burst_nxt = arburst;
          r_cnt_nxt   = '0;
          r_lat_nxt   = '0;
          r_err_nxt   = (arlen > 8'd15) || (arsize > 3'd2);
        end
      end
      R_WAIT: begin
        if (r_lat == LAT_W'(RD_LAT - 1)) begin
          r_state_nxt = R_DATA;
          rvalid_nxt  = 1'b1;
          rd_load     = 1'b1;
          rlast_nxt   = (r_cnt == r_len);
          rresp_nxt   = (r_err || !in_range(r_addr)) ? SLVERR : OKAY;
        end else begin
          r_lat_nxt = r_lat + LAT_W'(1);
        end
      end
      R_DATA: begin
        if (rvalid && rready) begin
          if (rlast) begin
            r_state_nxt = R_IDLE;
            rvalid_nxt  = 1'b0;
            rlast_nxt   = 1'b0;
            arready_nxt = 1'b1;
          end else begin
            r_addr_nxt = r_step;
            r_cnt_nxt  = r_cnt + 8'd1;
            rd_load    = 1'b1;
            rd_addr    = r_step;
            rlast_nxt  = ((r_cnt + 8'd1) == r_len);
            rresp_nxt  = (r_err || !in_range(r_step)) ? SLVERR : OKAY;
          end
        end
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  // ---------------- write engine ----------------
  w_state_t          w_state, w_state_nxt;
  logic [31:0]       w_addr, w_addr_nxt;
  logic [7:0]        w_len, w_len_nxt;
  logic [2:0]        w_size, w_size_nxt;
  logic [1:0]        w_burst, w_burst_nxt;
  logic [7:0]        w_cnt, w_cnt_nxt;
  logic [BL_W-1:0]   b_lat, b_lat_nxt;
  logic              w_err, w_err_nxt;
  logic [3:0]        aw_id, aw_id_nxt;
  logic              awready_nxt, wready_nxt, bvalid_nxt;
  logic [1:0]        bresp_nxt;
  logic [3:0]        bid_nxt;
  logic              mem_we;
  logic              w_at_len;

  always_ff @(posedge clk) begin
    if (!rst) begin
      w_state <= W_IDLE;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_cnt   <= '0;
      b_lat   <= '0;
      w_err   <= 1'b0;
      aw_id   <= '0;
      awready <= 1'b1;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bresp   <= OKAY;
      bid     <= '0;
    end else begin
      w_state <= w_state_nxt;
      w_addr  <= w_addr_nxt;
      w_len   <= w_len_nxt;
      w_size  <= w_size_nxt;
      w_burst <= w_burst_nxt;
      w_cnt   <= w_cnt_nxt;
      b_lat   <= b_lat_nxt;
      w_err   <= w_err_nxt;
      aw_id   <= aw_id_nxt;
      awready <= awready_nxt;
      wready  <= wready_nxt;
      bvalid  <= bvalid_nxt;
      bresp   <= bresp_nxt;
      bid     <= bid_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && mem_we) begin
      for (int i = 0; i < 4; i++)
        if (wstrb[i]) mem[w_addr[AW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
    end
  end

  always_comb begin
    w_state_nxt = w_state;
    w_addr_nxt  = w_addr;
    w_len_nxt   = w_len;
    w_size_nxt  = w_size;
    w_burst_nxt = w_burst;
    w_cnt_nxt   = w_cnt;
    b_lat_nxt   = b_lat;
    w_err_nxt   = w_err;
    aw_id_nxt   = aw_id;
    awready_nxt = awready;
    wready_nxt  = wready;
    bvalid_nxt  = bvalid;
    bresp_nxt   = bresp;
    bid_nxt     = bid;
    mem_we      = 1'b0;
    w_at_len    = (w_cnt == w_len);
    case (w_state)
      W_IDLE: begin
        if (awvalid && awready) begin
          w_state_nxt = W_DATA;
          awready_nxt = 1'b0;
          wready_nxt  = 1'b1;
          aw_id_nxt   = awid;
          w_addr_nxt  = awaddr;
          w_len_nxt   = awlen;
          w_size_nxt  = awsize;
          w_burst_nxt = awburst;
          w_cnt_nxt   = '0;
          w_err_nxt   = (awlen > 8'd15) || (awsize > 3'd2);
        end
      end
      W_DATA: begin
        if (wvalid && wready) begin
          mem_we    = in_range(w_addr);
          // burst ends on wlast or on the last counted beat, SLVERR if they disagree
          w_err_nxt = w_err || !in_range(w_addr) || (wlast != w_at_len);
          if (wlast || w_at_len) begin
            w_state_nxt = W_RESP;
            wready_nxt  = 1'b0;
            b_lat_nxt   = '0;
          end else begin
            w_addr_nxt = next_addr(w_addr, w_len, w_size, w_burst);
            w_cnt_nxt  = w_cnt + 8'd1;
          end
        end
      end
      W_RESP: begin
        if (!bvalid) begin
          if (b_lat == BL_W'(B_LAT - 1)) begin
            bvalid_nxt = 1'b1;
            bid_nxt    = aw_id;
            bresp_nxt  = w_err ? SLVERR : OKAY;
          end else begin
            b_lat_nxt = b_lat + BL_W'(1);
          end
        end else if (bready) begin
          bvalid_nxt  = 1'b0;
          awready_nxt = 1'b1;
          w_state_nxt = W_IDLE;
        end
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  // wid carries no information for this slave
  logic unused_wid;
  assign unused_wid = ^wid;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomized self-checking bench for axi_sram_slave against a burst-level memory model.
module tb_axi_sram_slave;
  localparam int unsigned DEPTH  = 1024;
  localparam int          RD_LAT = 2;
  localparam int          B_LAT  = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  arid = '0;
  logic [31:0] araddr = '0;
  logic [7:0]  arlen = '0;
  logic [2:0]  arsize = '0;
  logic [1:0]  arburst = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid;
  logic        rready = 1'b0;
  logic [3:0]  awid = '0;
  logic [31:0] awaddr = '0;
  logic [7:0]  awlen = '0;
  logic [2:0]  awsize = '0;
  logic [1:0]  awburst = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [3:0]  wid = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wlast = 1'b0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b0;

  axi_sram_slave #(.DEPTH(DEPTH), .RD_LAT(RD_LAT), .B_LAT(B_LAT)) dut (
    .clk(clk), .rst(rst),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] wbuf [32];
  logic [3:0]  sbuf [32];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Beat j address from the burst definition: WRAP stays inside an aligned L-byte window
  function automatic logic [31:0] beat_addr(input logic [31:0] s, input logic [7:0] len,
                                            input logic [2:0] sz, input logic [1:0] bu, input int j);
    logic [31:0] b, l, base;
    b = 32'd1 << sz;
    if (bu == 2'b10 && (len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) begin
      l    = (32'(len) + 32'd1) * b;
      base = s - (s % l);
      return base + ((s - base + 32'(j) * b) % l);
    end
    return s + 32'(j) * b;
  endfunction

  function automatic bit oor(input logic [31:0] a);
    return (a / 4) >= DEPTH;
  endfunction

  task automatic do_write(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                          input logic [2:0] sz, input logic [1:0] bu, input int nb, input bit gaps);
    int t, lat, d;
    logic [31:0] ba;
    bit err;
    awid = id; awaddr = a; awlen = len; awsize = sz; awburst = bu; awvalid = 1'b1;
    t = 0;
    while (!awready && t < 100) begin @(negedge clk); t++; end
    check("aw_ready", 32'(awready), 32'd1);
    @(negedge clk);
    awvalid = 1'b0;
    err = (len > 8'd15) || (sz > 3'd2) || (nb != int'(len) + 1);
    for (int i = 0; i < nb; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) @(negedge clk);
      wdata = wbuf[i]; wstrb = sbuf[i]; wlast = (i == nb - 1); wvalid = 1'b1;
      t = 0;
      while (!wready && t < 100) begin @(negedge clk); t++; end
      check("w_ready", 32'(wready), 32'd1);
      @(negedge clk);
      wvalid = 1'b0; wlast = 1'b0;
      ba = beat_addr(a, len, sz, bu, i);
      if (oor(ba)) err = 1'b1;
      else for (int k = 0; k < 4; k++)
        if (sbuf[i][k]) ref_mem[ba / 4][8*k +: 8] = wbuf[i][8*k +: 8];
    end
    lat = 0;
    while (!bvalid && lat < 100) begin @(negedge clk); lat++; end
    check("b_latency", 32'(lat), 32'(B_LAT));
    check("bresp", 32'(bresp), err ? 32'd2 : 32'd0);
    check("bid", 32'(bid), 32'(id));
    d = gaps ? $urandom_range(0, 2) : 0;
    repeat (d) begin @(negedge clk); check("b_hold", 32'(bvalid), 32'd1); end
    bready = 1'b1;
    @(negedge clk);
    bready = 1'b0;
    check("b_done", 32'(bvalid), 32'd0);
    check("aw_rearm", 32'(awready), 32'd1);
  endtask

  // rmode: 0 rready high, 1 rready toggles, 2 rready random
  task automatic do_read(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bu, input int rmode);
    int t, j, lat;
    logic [31:0] ba, ed;
    logic [1:0]  er;
    logic        rr;
    arid = id; araddr = a; arlen = len; arsize = sz; arburst = bu; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 100) begin @(negedge clk); t++; end
    check("ar_ready", 32'(arready), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid && lat < 100) begin @(negedge clk); lat++; end
    check("r_latency", 32'(lat), 32'(RD_LAT));
    j = 0; t = 0;
    while (j <= int'(len) && t < 2000) begin
      ba = beat_addr(a, len, sz, bu, j);
      ed = oor(ba) ? 32'd0 : ref_mem[ba / 4];
      er = (oor(ba) || len > 8'd15 || sz > 3'd2) ? 2'b10 : 2'b00;
      check("rvalid", 32'(rvalid), 32'd1);
      check("rdata", rdata, ed);
      check("rresp", 32'(rresp), 32'(er));
      check("rlast", 32'(rlast), 32'(j == int'(len)));
      check("rid", 32'(rid), 32'(id));
      rr = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'(t % 2 == 0) : 1'($urandom_range(0, 1));
      rready = rr;
      if (rr) j++;
      t++;
      @(negedge clk);
    end
    rready = 1'b0;
    check("r_done", 32'(rvalid), 32'd0);
    check("ar_rearm", 32'(arready), 32'd1);
  endtask

  initial begin
    int t, sel, nb;
    logic [31:0] a, ed;
    logic [7:0]  len;
    logic [2:0]  sz;
    logic [1:0]  bu;

    repeat (3) @(negedge clk);
    check("rst_arready", 32'(arready), 32'd1);
    check("rst_awready", 32'(awready), 32'd1);
    check("rst_wready", 32'(wready), 32'd0);
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_rlast", 32'(rlast), 32'd0);
    check("rst_ids", 32'({rid, bid}), 32'd0);
    check("rst_resps", 32'({rresp, bresp}), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // fill the whole RAM with known random contents
    for (int w = 0; w < int'(DEPTH) / 16; w++) begin
      for (int i = 0; i < 16; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
      do_write(4'(w), 32'(w * 64), 8'd15, 3'd2, 2'b01, 16, 1'b0);
    end

    // single write/read, strobes
    wbuf[0] = 32'hDEADBEEF; sbuf[0] = 4'hF;
    do_write(4'h5, 32'h100, 8'd0, 3'd2, 2'b01, 1, 1'b0);
    do_read(4'h6, 32'h100, 8'd0, 3'd2, 2'b01, 0);
    wbuf[0] = 32'h11223344; sbuf[0] = 4'hF;
    do_write(4'h1, 32'h40, 8'd0, 3'd2, 2'b01, 1, 1'b0);
    wbuf[0] = 32'hAABBCCDD; sbuf[0] = 4'b0010;
    do_write(4'h2, 32'h40, 8'd0, 3'd2, 2'b01, 1, 1'b0);
    do_read(4'h3, 32'h40, 8'd0, 3'd2, 2'b01, 0);

    // INCR with pulsed rready, WRAP on both paths
    for (int i = 0; i < 8; i++) begin wbuf[i] = 32'(i); sbuf[i] = 4'hF; end
    do_write(4'h4, 32'h200, 8'd7, 3'd2, 2'b01, 8, 1'b0);
    do_read(4'h7, 32'h200, 8'd7, 3'd2, 2'b01, 1);
    do_read(4'h2, 32'h38, 8'd3, 3'd2, 2'b10, 2);
    for (int i = 0; i < 4; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
    do_write(4'h3, 32'h38, 8'd3, 3'd2, 2'b10, 4, 1'b1);
    do_read(4'h4, 32'h30, 8'd3, 3'd2, 2'b01, 0);

    // out of range, concurrency, protocol errors
    do_read(4'h7, 32'(4 * DEPTH), 8'd1, 3'd2, 2'b01, 0);
    for (int i = 0; i < 2; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
    do_write(4'h8, 32'(4 * DEPTH), 8'd1, 3'd2, 2'b01, 2, 1'b0);
    do_read(4'h9, 32'h0, 8'd15, 3'd2, 2'b01, 2);
    for (int i = 0; i < 4; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'hF; end
    fork
      do_write(4'hA, 32'h300, 8'd3, 3'd2, 2'b01, 4, 1'b1);
      do_read(4'hB, 32'h500, 8'd7, 3'd2, 2'b01, 2);
    join
    do_read(4'hC, 32'h300, 8'd3, 3'd2, 2'b01, 0);
    do_write(4'hC, 32'h600, 8'd3, 3'd2, 2'b01, 2, 1'b0);
    do_read(4'hD, 32'h700, 8'd17, 3'd2, 2'b01, 0);
    do_read(4'hE, 32'h700, 8'd1, 3'd3, 2'b01, 0);

    // reset while beat 3 of 8 is on the bus
    arid = 4'hA; araddr = 32'h200; arlen = 8'd7; arsize = 3'd2; arburst = 2'b01; arvalid = 1'b1;
    t = 0;
    while (!arready && t < 100) begin @(negedge clk); t++; end
    check("rst_test_ar", 32'(arready), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    rready = 1'b1;
    t = 0;
    while (!rvalid && t < 100) begin @(negedge clk); t++; end
    for (int j = 0; j < 3; j++) @(negedge clk);
    ed = ref_mem[(32'h200 + 12) / 4];
    check("rst_test_beat3", rdata, ed);
    rst = 1'b0; rready = 1'b0;
    @(negedge clk);
    check("mid_rst_rvalid", 32'(rvalid), 32'd0);
    check("mid_rst_arready", 32'(arready), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    do_read(4'h1, 32'h200, 8'd7, 3'd2, 2'b01, 0);
    do_read(4'h2, 32'h100, 8'd0, 3'd2, 2'b01, 0);

    // random traffic
    for (int k = 0; k < 60; k++) begin
      sel = $urandom_range(0, 9);
      sz  = (sel == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      len = (sel == 1) ? 8'($urandom_range(16, 20)) : 8'($urandom_range(0, 15));
      bu  = 2'($urandom_range(0, 2));
      case (sel)
        2: a = 32'(4 * DEPTH - 8);
        3: a = 32'hFFFF_FFF8;
        default: a = 32'($urandom_range(0, 4 * DEPTH - 1));
      endcase
      if ($urandom_range(0, 1) == 1) begin
        nb = (sel == 4) ? $urandom_range(1, int'(len) + 1) : int'(len) + 1;
        for (int i = 0; i < nb; i++) begin wbuf[i] = $urandom; sbuf[i] = 4'($urandom); end
        do_write(4'($urandom), a, len, sz, bu, nb, 1'b1);
      end else begin
        do_read(4'($urandom), a, len, sz, bu, 2);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
